// File: rtl/sort_pkg.sv
// Shared sorter definitions: default array geometry and readout FSM states.
package sort_pkg;

    localparam int unsigned SORT_DATA_WIDTH = 8;
    localparam int unsigned SORT_DEPTH      = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SEND  = 3'd3,
        CLEAR = 3'd4
    } rdr_state_t;

endpackage

// File: rtl/sort_result_reader.sv
// Streams the sorted array out of the sort memory once the end-of-conversion
// flag is set, then pulses clear_eoc to release the flag.
module sort_result_reader
    import sort_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SORT_DATA_WIDTH,
    parameter int unsigned DEPTH      = SORT_DEPTH,
    parameter int unsigned ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  eoc_in,
    output logic                  clear_eoc,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    rdr_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    // State, index and output holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
        end
    end

    // Next-state: one fetch/load/send pass per word, then a single clear cycle.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_data_d = out_data_q;
        unique case (state_q)
            IDLE: begin
                if (eoc_in) begin
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                out_data_d = rd_data;
                state_d    = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = CLEAR;
                    end else begin
                        idx_d   = idx_q + ADDR_WIDTH'(1);
                        state_d = FETCH;
                    end
                end
            end
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from registered state only; out_ready never reaches them.
    assign rd_en     = (state_q == FETCH);
    assign rd_addr   = idx_q;
    assign out_data  = out_data_q;
    assign out_valid = (state_q == SEND);
    assign out_last  = (state_q == SEND) && (idx_q == LAST_IDX);
    assign clear_eoc = (state_q == CLEAR);
    assign busy      = (state_q != IDLE);

endmodule
